// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with load, direction, illegal-state
// detection/correction and binary, one-hot and terminal-count decode.
module johnson_counter_gen #(
    parameter int unsigned WIDTH        = 4,
    parameter bit          SELF_CORRECT = 1'b1,
    parameter int unsigned IDXW         = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     state,
    output logic [IDXW-1:0]      idx,
    output logic [2*WIDTH-1:0]   dec,
    output logic                 tc,
    output logic                 illegal
);

    localparam logic [IDXW-1:0] IdxLast  = IDXW'(2 * WIDTH - 1);
    localparam logic [IDXW-1:0] IdxFirst = IDXW'(1);

    // Valid codes are a single run of ones against a single run of zeros,
    // i.e. at most one adjacent-bit transition.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (v[i] != v[i+1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_fwd;
    logic [WIDTH-1:0] step_rev;
    logic             load_legal;
    logic [IDXW-1:0]  pos;
    int unsigned      ones;

    assign state      = state_q;
    assign illegal    = ~is_legal(state_q);
    assign load_legal = is_legal(load_val);

    assign step_fwd = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
    assign step_rev = {~state_q[0], state_q[WIDTH-1:1]};

    // Position in the sequence: the ones-run grows from stage 0 during the first
    // half and drains from stage 0 during the second half.
    always_comb begin
        ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (state_q[i]) begin
                ones++;
            end
        end
        if (state_q[0] || (state_q == '0)) begin
            pos = IDXW'(ones);
        end else begin
            pos = IDXW'(2 * WIDTH - ones);
        end
    end

    always_comb begin
        idx = '0;
        dec = '0;
        if (!illegal) begin
            idx      = pos;
            dec[pos] = 1'b1;
        end
    end

    always_comb begin
        tc = 1'b0;
        if (en && !load && !illegal) begin
            tc = dir ? (idx == IdxFirst) : (idx == IdxLast);
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            if (load_legal || !SELF_CORRECT) begin
                state_d = load_val;
            end else begin
                state_d = '0;
            end
        end else if (illegal && SELF_CORRECT) begin
            state_d = '0;
        end else if (en) begin
            state_d = dir ? step_rev : step_fwd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Bench for johnson_counter_gen: two WIDTH=4 instances (correcting and non-correcting)
// checked every cycle against a position-based model plus directed literal checks.
module tb_johnson_counter_gen;

    localparam int W  = 4;
    localparam int N  = 2 * W;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;

    logic [W-1:0]  st_a, st_b;
    logic [IW-1:0] idx_a, idx_b;
    logic [N-1:0]  dec_a, dec_b;
    logic          tc_a, tc_b, ill_a, ill_b;

    johnson_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .state(st_a), .idx(idx_a), .dec(dec_a), .tc(tc_a), .illegal(ill_a)
    );

    johnson_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .state(st_b), .idx(idx_b), .dec(dec_b), .tc(tc_b), .illegal(ill_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a legal state is just a position 0..N-1; an illegal one is a raw vector.
    bit           m_legal[2] = '{1'b1, 1'b1};
    int           m_pos[2]   = '{0, 0};
    logic [W-1:0] m_raw[2]   = '{4'b0000, 4'b0000};

    logic [W-1:0] fwd_exp[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [W-1:0] rev_exp[8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [11:0]  dpat       = 12'b101100111010;

    // Code word at position p: ones fill from stage 0, then drain from stage 0.
    function automatic logic [W-1:0] code_of(input int p);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            v[i] = (p <= W) ? (i < p) : (i >= p - W);
        end
        return v;
    endfunction

    function automatic int pos_of(input logic [W-1:0] v);
        for (int p = 0; p < N; p++) begin
            if (code_of(p) == v) return p;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk or posedge rst);
                for (int i = 0; i < 2; i++) begin
                    bit sc;
                    int p;
                    sc = (i == 0);
                    if (rst) begin
                        m_legal[i] = 1'b1;
                        m_pos[i]   = 0;
                    end else if (load) begin
                        p = pos_of(load_val);
                        if (p >= 0) begin
                            m_legal[i] = 1'b1;
                            m_pos[i]   = p;
                        end else if (sc) begin
                            m_legal[i] = 1'b1;
                            m_pos[i]   = 0;
                        end else begin
                            m_legal[i] = 1'b0;
                            m_raw[i]   = load_val;
                        end
                    end else if (!m_legal[i] && sc) begin
                        m_legal[i] = 1'b1;
                        m_pos[i]   = 0;
                    end else if (en) begin
                        if (m_legal[i]) begin
                            m_pos[i] = (m_pos[i] + (dir ? N - 1 : 1)) % N;
                        end else begin
                            m_raw[i] = dir ? {~m_raw[i][0], m_raw[i][W-1:1]}
                                           : {m_raw[i][W-2:0], ~m_raw[i][W-1]};
                            p = pos_of(m_raw[i]);
                            if (p >= 0) begin
                                m_legal[i] = 1'b1;
                                m_pos[i]   = p;
                            end
                        end
                    end
                end
            end
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    logic [W-1:0] es;
                    int           ei;
                    logic [31:0]  ed;
                    bit           etc;
                    es  = m_legal[i] ? code_of(m_pos[i]) : m_raw[i];
                    ei  = m_legal[i] ? m_pos[i] : 0;
                    ed  = m_legal[i] ? (32'd1 << m_pos[i]) : 32'd0;
                    etc = en && !load && m_legal[i] &&
                          ((!dir && m_pos[i] == N - 1) || (dir && m_pos[i] == 1));
                    chk(i == 0 ? "a_state" : "b_state", 32'(i == 0 ? st_a : st_b), 32'(es));
                    chk(i == 0 ? "a_idx" : "b_idx", 32'(i == 0 ? idx_a : idx_b), 32'(ei));
                    chk(i == 0 ? "a_dec" : "b_dec", 32'(i == 0 ? dec_a : dec_b), ed);
                    chk(i == 0 ? "a_tc" : "b_tc", 32'(i == 0 ? tc_a : tc_b), 32'(etc));
                    chk(i == 0 ? "a_illegal" : "b_illegal", 32'(i == 0 ? ill_a : ill_b),
                        32'(!m_legal[i]));
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Forward full lap.
        @(posedge clk);
        #2 en = 1'b1; dir = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("fwd_state", 32'(st_a), 32'(fwd_exp[k]));
            chk("fwd_idx", 32'(idx_a), 32'((k + 1) % 8));
            chk("fwd_tc", 32'(tc_a), 32'(k == 6));
        end

        // Reverse full lap.
        #1 dir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("rev_state", 32'(st_a), 32'(rev_exp[k]));
            chk("rev_idx", 32'(idx_a), 32'(7 - k));
            chk("rev_tc", 32'(tc_a), 32'(k == 6));
        end

        // Hold mid-sequence.
        #1;
        repeat (3) @(posedge clk);
        #2 en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("hold_state", 32'(st_a), 32'(4'b1110));
            chk("hold_tc", 32'(tc_a), 32'(0));
            #1;
        end

        // Direction changes on arbitrary cycles.
        en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            dir = dpat[j];
            @(posedge clk);
            #2;
        end

        // Mid-cycle asynchronous reset.
        en = 1'b0; load = 1'b1; load_val = 4'b0011;
        @(posedge clk);
        #2 load = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(st_a), 32'(4'b0000));
        chk("arst_idx", 32'(idx_a), 32'(0));
        chk("arst_dec", 32'(dec_a), 32'(8'h01));
        chk("arst_illegal", 32'(ill_a), 32'(0));
        @(posedge clk);
        #2 rst = 1'b0;

        // Legal load overrides en.
        en = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'b0111;
        @(posedge clk);
        #1;
        chk("load_state", 32'(st_a), 32'(4'b0111));
        chk("load_idx", 32'(idx_a), 32'(3));
        #1 load = 1'b0;
        @(posedge clk);
        #1;
        chk("after_load_state", 32'(st_a), 32'(4'b1111));
        #1;

        // Illegal load: corrected on a, parasitic loop on b.
        load = 1'b1; load_val = 4'b0101;
        @(posedge clk);
        #1;
        chk("ill_load_a_state", 32'(st_a), 32'(4'b0000));
        chk("ill_load_a_illegal", 32'(ill_a), 32'(0));
        chk("ill_load_b_state", 32'(st_b), 32'(4'b0101));
        chk("ill_load_b_dec", 32'(dec_b), 32'(0));
        #1 load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("parasitic_illegal", 32'(ill_b), 32'(1));
            chk("parasitic_dec", 32'(dec_b), 32'(0));
            #1;
        end
        #1 rst = 1'b1;
        #1;
        chk("b_rst_state", 32'(st_b), 32'(4'b0000));
        chk("b_rst_illegal", 32'(ill_b), 32'(0));
        en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Deposited illegal state is corrected on the next edge with en=0.
        force dut_a.state_q = 4'b0010;
        m_legal[0] = 1'b0;
        m_raw[0]   = 4'b0010;
        #1;
        chk("dep_illegal", 32'(ill_a), 32'(1));
        chk("dep_dec", 32'(dec_a), 32'(0));
        chk("dep_idx", 32'(idx_a), 32'(0));
        #4 release dut_a.state_q;
        @(posedge clk);
        #1;
        chk("corr_state", 32'(st_a), 32'(4'b0000));
        chk("corr_illegal", 32'(ill_a), 32'(0));
        chk("corr_dec", 32'(dec_a), 32'(8'h01));

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
